sdram_arbiter: RTL and testbench

- Shares the single-port SDRAM controller between NREQ requesters: port 0 is video refresh, port 1 is CPU, port 2 is floppy/DMA.
- Converts each requester's level req/ack handshake into the controller's edge-triggered rd/we strobes.
- Tracks controller ready, including the same-word read fast path where ready never drops, and returns read data with a one-cycle ack.
- Sits between the bus/video logic and the SDRAM controller in the top level.

---
 rtl/sdram_arb_pkg.sv | 17 +
 rtl/sdram_arbiter_rr_pick.sv | 28 ++
 rtl/sdram_arbiter.sv | 145 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM arbiter: FSM state encoding and requester port indices.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GUARD1,
    GUARD2,
    WAIT,
    DONE
  } state_t;

  localparam logic [1:0] PORT_VIDEO = 2'd0;
  localparam logic [1:0] PORT_CPU   = 2'd1;
  localparam logic [1:0] PORT_DMA   = 2'd2;

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of req searching upward from start, with wrap.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   start,
  output logic [1:0]   idx,
  output logic         valid
);

  int p;

  // Walk from the farthest candidate back to start so the nearest set bit is written last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    p     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      p = int'(start) + k;
      if (p >= N) p = p - N;
      if (req[p]) begin
        idx   = 2'(p);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates NREQ level req/ack requesters onto the SDRAM controller's edge-triggered rd/we strobes.
//   state  | meaning
//   IDLE   | arbitrate when a req is pending and the controller is ready
//   ISSUE  | raise sd_rd or sd_we for the granted access
//   GUARD1 | strobe held, sd_ready ignored (controller ready-drop latency)
//   GUARD2 | strobe held, sd_ready ignored, timeout counter loaded
//   WAIT   | strobe held until sd_ready or timeout; read data captured on exit
//   DONE   | strobe dropped, one-cycle ack to the granted port
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int AW      = 25,
  parameter int P0_MAX  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*16-1:0] req_din,
  input  logic [NREQ*2-1:0] req_wtbt,
  output logic [NREQ-1:0]   ack,
  output logic [15:0]       rdata,
  output logic [1:0]        grant_id,
  output logic              busy,
  output logic              err,
  output logic [AW-1:0]     sd_addr,
  output logic [15:0]       sd_din,
  output logic [1:0]        sd_wtbt,
  output logic              sd_we,
  output logic              sd_rd,
  input  logic [15:0]       sd_dout,
  input  logic              sd_ready
);

  localparam int CW = $clog2(P0_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] P0_LIMIT = CW'(P0_MAX);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
  localparam logic [1:0]    LAST_PORT = 2'(NREQ - 1);

  state_t          state;
  logic [1:0]      rr_ptr;
  logic [CW-1:0]   p0_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            we_q;

  logic [NREQ-2:0] other_req;
  logic            other_pend;
  logic            p0_win;
  logic            pick_valid;
  logic            grant_ok;
  logic [1:0]      pick_idx;
  logic [1:0]      pick_start;
  logic [1:0]      win_id;

  assign other_req  = req[NREQ-1:1];
  assign other_pend = |other_req;
  assign p0_win     = req[PORT_VIDEO] && !(p0_cnt == P0_LIMIT && other_pend);
  // rr_ptr of 0 (post-reset) starts the search at port 1, same as rr_ptr of 1.
  assign pick_start = (rr_ptr == 2'd0) ? 2'd0 : rr_ptr - 2'd1;
  assign win_id     = p0_win ? PORT_VIDEO : pick_idx + 2'd1;
  assign grant_ok   = sd_ready && (p0_win || pick_valid);

  rr_pick #(.N(NREQ - 1)) u_rr_pick (
    .req   (other_req),
    .start (pick_start),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state    <= IDLE;
      sd_we    <= 1'b0;
      sd_rd    <= 1'b0;
      ack      <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= '0;
      p0_cnt   <= '0;
      rdata    <= '0;
      sd_addr  <= '0;
      sd_din   <= '0;
      sd_wtbt  <= '0;
      we_q     <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            sd_addr  <= req_addr[win_id*AW +: AW];
            sd_din   <= req_din[win_id*16 +: 16];
            sd_wtbt  <= req_wtbt[win_id*2 +: 2];
            we_q     <= req_we[win_id];
            grant_id <= win_id;
            busy     <= 1'b1;
            state    <= ISSUE;
            if (p0_win) begin
              if (!other_pend)            p0_cnt <= '0;
              else if (p0_cnt != P0_LIMIT) p0_cnt <= p0_cnt + 1'b1;
            end else begin
              rr_ptr <= (win_id == LAST_PORT) ? 2'd1 : win_id + 2'd1;
              p0_cnt <= '0;
            end
          end
        end
        ISSUE: begin
          sd_we <= we_q;
          sd_rd <= !we_q;
          state <= GUARD1;
        end
        GUARD1: state <= GUARD2;
        GUARD2: begin
          tmo_cnt <= TMO_LOAD;
          state   <= WAIT;
        end
        WAIT: begin
          if (sd_ready) begin
            if (!we_q) rdata <= sd_dout;
            state <= DONE;
          end else if (tmo_cnt == '0) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        DONE: begin
          sd_we <= 1'b0;
          sd_rd <= 1'b0;
          ack   <= NREQ'(1) << grant_id;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter with a behavioural SDRAM controller and arbitration model.
module tb_sdram_arbiter;

  localparam int NREQ = 3, AW = 25, P0_MAX = 4, TIMEOUT = 255;
  localparam int M_NORMAL = 0, M_HIT = 1, M_DEAD = 2;

  logic clk = 1'b0;
  logic init_n = 1'b0;
  logic [NREQ-1:0]    req = '0, req_we = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*16-1:0] req_din = '0;
  logic [NREQ*2-1:0]  req_wtbt = '0;
  logic [NREQ-1:0]    ack;
  logic [15:0]        rdata, sd_din, sd_dout;
  logic [1:0]         grant_id, sd_wtbt;
  logic               busy, err, sd_we, sd_rd;
  logic [AW-1:0]      sd_addr;
  logic               sd_ready = 1'b1;

  int checks = 0, errors = 0;
  int mode = M_NORMAL, lat = 2;
  int lat_cnt = 0;
  logic strobe_q = 1'b0;
  int streak = 0, rr_next = 1;
  logic [15:0] last_rd;

  int o_lat, o_rise, o_we_high, o_ack_cnt;
  logic [NREQ-1:0] o_ack;
  logic [15:0] o_rdata, o_din2;
  logic [1:0] o_gid, o_wtbt2;
  logic [AW-1:0] o_addr2;
  logic o_err, o_err_mid;

  always #5 clk = ~clk;

  sdram_arbiter #(.NREQ(NREQ), .AW(AW), .P0_MAX(P0_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .init_n(init_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_din(req_din), .req_wtbt(req_wtbt), .ack(ack), .rdata(rdata), .grant_id(grant_id),
    .busy(busy), .err(err), .sd_addr(sd_addr), .sd_din(sd_din), .sd_wtbt(sd_wtbt),
    .sd_we(sd_we), .sd_rd(sd_rd), .sd_dout(sd_dout), .sd_ready(sd_ready)
  );

  function automatic logic [15:0] rd_word(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA45A;
  endfunction

  // Controller model: read data is a fixed function of the address; ready drops on a strobe edge.
  assign sd_dout = rd_word(sd_addr);

  always @(negedge clk) begin
    strobe_q <= sd_rd | sd_we;
    if ((sd_rd | sd_we) && !strobe_q && mode != M_HIT) begin
      sd_ready <= 1'b0;
      lat_cnt  <= lat;
    end else if (!sd_ready && mode != M_DEAD) begin
      if (lat_cnt == 0) sd_ready <= 1'b1;
      else lat_cnt <= lat_cnt - 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_port(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [15:0] d, input logic [1:0] bt);
    req_we[p] = we;
    req_addr[p*AW +: AW] = a;
    req_din[p*16 +: 16] = d;
    req_wtbt[p*2 +: 2] = bt;
    req[p] = 1'b1;
  endtask

  task automatic load_port(input int p);
    set_port(p, 1'($urandom_range(0, 1)), AW'($urandom), 16'($urandom), 2'($urandom));
  endtask

  task automatic apply_reset;
    @(negedge clk);
    init_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    init_n = 1'b1;
    @(negedge clk);
  endtask

  // Reference arbitration: video first unless its streak limit is hit, else round-robin over 1..NREQ-1.
  task automatic model_grant(input logic [NREQ-1:0] r, output int w);
    logic others;
    int p;
    others = |r[NREQ-1:1];
    w = -1;
    if (r[0] && !(streak == P0_MAX && others)) w = 0;
    else begin
      for (int k = 0; k < NREQ - 1; k++) begin
        p = (rr_next - 1 + k) % (NREQ - 1) + 1;
        if (w < 0 && r[p]) w = p;
      end
    end
    if (w == 0) begin
      if (!others) streak = 0;
      else if (streak < P0_MAX) streak++;
    end else if (w > 0) begin
      rr_next = (w == NREQ - 1) ? 1 : w + 1;
      streak = 0;
    end
  endtask

  task automatic single_access(input int p, input logic we, input logic [AW-1:0] a,
                               input logic [15:0] d, input logic [1:0] bt, input int bound);
    @(negedge clk);
    set_port(p, we, a, d, bt);
    o_lat = -1; o_rise = -1; o_we_high = 0; o_ack_cnt = 0; o_err_mid = 1'bx;
    o_ack = '0; o_rdata = 'x; o_gid = 'x; o_err = 1'bx;
    for (int k = 1; k <= bound && o_lat < 0; k++) begin
      @(negedge clk);
      if (o_rise < 0 && sd_rd) o_rise = k;
      if (sd_we) o_we_high++;
      if (k == 2) begin o_addr2 = sd_addr; o_din2 = sd_din; o_wtbt2 = sd_wtbt; end
      if (k == 100) o_err_mid = err;
      if (ack != '0) begin
        o_lat = k; o_ack = ack; o_rdata = rdata; o_gid = grant_id; o_err = err;
        o_ack_cnt++;
        req[p] = 1'b0;
      end
    end
    repeat (8) begin
      @(negedge clk);
      if (ack != '0) o_ack_cnt++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if ({sd_we, sd_rd, busy, err} !== 4'b0) begin errors++; $display("FAIL reset_ctl: got %b want 0000", {sd_we, sd_rd, busy, err}); end
    checks++; if (ack !== '0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if ({sd_addr, sd_din, sd_wtbt} !== '0) begin errors++; $display("FAIL reset_sd_bus: got %h/%h/%b want 0", sd_addr, sd_din, sd_wtbt); end
    init_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_read;
    mode = M_NORMAL; lat = 3;
    single_access(1, 1'b0, 25'h000100, 16'h0, 2'b11, 60);
    checks++; if (o_rise !== 2) begin errors++; $display("FAIL cpu_rd_rise: got %0d want 2", o_rise); end
    checks++; if (o_ack !== 3'b010) begin errors++; $display("FAIL cpu_ack: got %b want 010", o_ack); end
    checks++; if (o_ack_cnt !== 1) begin errors++; $display("FAIL cpu_ack_count: got %0d want 1", o_ack_cnt); end
    checks++; if (o_rdata !== 16'hA55A) begin errors++; $display("FAIL cpu_rdata: got %h want a55a", o_rdata); end
    checks++; if (o_gid !== 2'd1) begin errors++; $display("FAIL cpu_grant_id: got %0d want 1", o_gid); end
    last_rd = 16'hA55A;
  endtask

  task automatic test_read_hit;
    int p;
    logic [AW-1:0] a;
    mode = M_HIT;
    for (int i = 0; i < 3; i++) begin
      p = $urandom_range(0, NREQ - 1);
      a = AW'($urandom);
      single_access(p, 1'b0, a, 16'h0, 2'b11, 30);
      checks++; if (o_lat !== 6) begin errors++; $display("FAIL hit_latency: got %0d want 6", o_lat); end
      checks++; if (o_ack !== NREQ'(1 << p)) begin errors++; $display("FAIL hit_ack: got %b want port %0d", o_ack, p); end
      checks++; if (o_rdata !== rd_word(a)) begin errors++; $display("FAIL hit_rdata: got %h want %h", o_rdata, rd_word(a)); end
      last_rd = rd_word(a);
    end
  endtask

  task automatic test_dma_write;
    mode = M_NORMAL; lat = $urandom_range(1, 5);
    single_access(2, 1'b1, 25'h001FFFE, 16'h1234, 2'b11, 60);
    checks++; if (o_addr2 !== 25'h001FFFE) begin errors++; $display("FAIL dma_addr: got %h want 1fffe", o_addr2); end
    checks++; if (o_din2 !== 16'h1234) begin errors++; $display("FAIL dma_din: got %h want 1234", o_din2); end
    checks++; if (o_wtbt2 !== 2'b11) begin errors++; $display("FAIL dma_wtbt: got %b want 11", o_wtbt2); end
    checks++; if (o_lat < 6 || o_we_high !== o_lat - 2) begin errors++; $display("FAIL dma_we_held: got %0d high cycles want %0d", o_we_high, o_lat - 2); end
    checks++; if (o_rise !== -1) begin errors++; $display("FAIL dma_no_rd: got rd at %0d want none", o_rise); end
    checks++; if (o_ack !== 3'b100 || o_ack_cnt !== 1) begin errors++; $display("FAIL dma_ack: got %b x%0d want 100 x1", o_ack, o_ack_cnt); end
    checks++; if (o_rdata !== last_rd) begin errors++; $display("FAIL dma_rdata_hold: got %h want %h", o_rdata, last_rd); end
  endtask

  task automatic test_timeout;
    logic [AW-1:0] a;
    logic saw_busy;
    int got;
    mode = M_DEAD;
    a = AW'($urandom);
    single_access(1, 1'b0, a, 16'h0, 2'b00, 400);
    checks++; if (o_err_mid !== 1'b0) begin errors++; $display("FAIL tmo_err_early: got %b want 0", o_err_mid); end
    checks++; if (o_lat !== TIMEOUT + 5) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", o_lat, TIMEOUT + 5); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", o_err); end
    checks++; if (o_ack !== 3'b010) begin errors++; $display("FAIL tmo_ack: got %b want 010", o_ack); end
    checks++; if (o_rdata !== last_rd) begin errors++; $display("FAIL tmo_rdata_hold: got %h want %h", o_rdata, last_rd); end
    // Controller still not ready: the new request must wait in IDLE.
    a = AW'($urandom);
    @(negedge clk);
    set_port(2, 1'b0, a, 16'h0, 2'b11);
    saw_busy = 1'b0;
    repeat (6) begin @(negedge clk); saw_busy |= busy | sd_rd; end
    checks++; if (saw_busy !== 1'b0) begin errors++; $display("FAIL notready_grant: got busy want idle"); end
    mode = M_NORMAL; lat = 2;
    got = 0;
    for (int k = 0; k < 60 && got == 0; k++) begin
      @(negedge clk);
      if (ack != '0) begin
        got = 1;
        checks++; if (ack !== 3'b100) begin errors++; $display("FAIL after_tmo_ack: got %b want 100", ack); end
        checks++; if (rdata !== rd_word(a)) begin errors++; $display("FAIL after_tmo_rdata: got %h want %h", rdata, rd_word(a)); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
        req[2] = 1'b0;
      end
    end
    checks++; if (got !== 1) begin errors++; $display("FAIL after_tmo_served: got no ack want ack"); end
    last_rd = rd_word(a);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [AW-1:0] a;
    int bad_ack, got;
    mode = M_NORMAL; lat = 6;
    a = AW'($urandom);
    @(negedge clk);
    set_port(1, 1'b0, a, 16'h0, 2'b11);
    repeat (3) @(negedge clk);
    checks++; if (sd_rd !== 1'b1) begin errors++; $display("FAIL mid_pre_rd: got %b want 1", sd_rd); end
    init_n = 1'b0;
    #1;
    checks++; if (sd_rd !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_drop: got rd=%b busy=%b want 0 0", sd_rd, busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_reset_err: got %b want 0", err); end
    bad_ack = 0;
    repeat (3) begin @(negedge clk); if (ack != '0) bad_ack++; end
    init_n = 1'b1;
    got = 0;
    for (int k = 0; k < 60 && got == 0; k++) begin
      @(negedge clk);
      if (ack != '0) begin
        got = 1;
        checks++; if (ack !== 3'b010) begin errors++; $display("FAIL mid_reserve_ack: got %b want 010", ack); end
        checks++; if (rdata !== rd_word(a)) begin errors++; $display("FAIL mid_reserve_rdata: got %h want %h", rdata, rd_word(a)); end
        req[1] = 1'b0;
      end
    end
    checks++; if (bad_ack !== 0 || got !== 1) begin errors++; $display("FAIL mid_ack_count: got reset-acks=%0d served=%0d want 0 1", bad_ack, got); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_arbitration;
    int exp_port, obs;
    int seq[11];
    seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0};
    apply_reset;
    mode = M_NORMAL; lat = 1;
    streak = 0; rr_next = 1;
    for (int p = 0; p < NREQ; p++) load_port(p);
    model_grant(req, exp_port);
    for (int n = 0; n < 50; n++) begin
      obs = -1;
      for (int k = 0; k < 80 && obs < 0; k++) begin
        @(negedge clk);
        if (ack != '0) obs = onehot_idx(ack);
      end
      checks++; if (obs !== exp_port) begin errors++; $display("FAIL arb_grant_%0d: got port %0d want %0d", n, obs, exp_port); end
      if (obs < 0) break;
      if (n < 11) begin
        checks++; if (obs !== seq[n]) begin errors++; $display("FAIL arb_fixed_seq_%0d: got port %0d want %0d", n, obs, seq[n]); end
      end
      checks++; if (ack !== NREQ'(1 << obs) || grant_id !== 2'(obs)) begin errors++; $display("FAIL arb_ack_shape_%0d: got ack %b id %0d want port %0d", n, ack, grant_id, obs); end
      if (!req_we[obs]) begin
        checks++; if (rdata !== rd_word(req_addr[obs*AW +: AW])) begin errors++; $display("FAIL arb_rdata_%0d: got %h want %h", n, rdata, rd_word(req_addr[obs*AW +: AW])); end
      end
      if (n < 10) load_port(obs);
      else begin
        if ($urandom_range(0, 1) == 1) load_port(obs);
        else req[obs] = 1'b0;
        for (int p = 0; p < NREQ; p++) if (!req[p] && $urandom_range(0, 2) == 0) load_port(p);
        if (req == '0) load_port($urandom_range(0, NREQ - 1));
      end
      lat = $urandom_range(0, 4);
      model_grant(req, exp_port);
    end
    req = '0;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_cpu_read;
    test_read_hit;
    test_dma_write;
    test_timeout;
    test_reset_mid;
    test_arbitration;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
